// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit slice.
//   - dcache uop codes (the dcache decodes the same values).
//   - FSM state encoding used by load_store_unit.
//   - is_mem_uop(): true for the two uops that touch the dcache.
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [4:0] NOP_UOP = 5'b00000;
  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_uop(input logic [4:0] uop);
    return (uop == LDR_UOP) || (uop == STR_UOP);
  endfunction

endpackage

// File: rtl/lsu_agu.sv
// ---------------------------------------------------------------------------
// lsu_agu
//   Combinational ARM-style address generation for LDR/STR.
//   eff = base +/- zero-extended offset (mod 2^32); acc = pre ? eff : base.
// Ports
//   base      in   32          base register value
//   offset    in   OFF_W       unsigned immediate offset
//   up        in   1           1: add offset, 0: subtract
//   pre       in   1           1: access at eff, 0: access at base
//   eff       out  32          updated base (writeback value)
//   word_idx  out  DEPTH_LOG2  dcache word index taken from acc
//   misalign  out  1           acc is not word aligned
// ---------------------------------------------------------------------------
module lsu_agu #(
  parameter int DEPTH_LOG2 = 5,
  parameter int OFF_W      = 12
) (
  input  logic [31:0]           base,
  input  logic [OFF_W-1:0]      offset,
  input  logic                  up,
  input  logic                  pre,
  output logic [31:0]           eff,
  output logic [DEPTH_LOG2-1:0] word_idx,
  output logic                  misalign
);

  logic [31:0] offset_ext;
  logic [31:0] acc;
  logic        unused_acc_hi;

  // Upper acc bits are intentionally dropped: addresses alias modulo the
  // dcache size, so only the word-index bits reach the dcache.
  always_comb begin
    offset_ext = {{(32-OFF_W){1'b0}}, offset};
    eff        = up ? (base + offset_ext) : (base - offset_ext);
    acc        = pre ? eff : base;
    word_idx   = acc[DEPTH_LOG2+1:2];
    misalign   = (acc[1:0] != 2'b00);
  end

  assign unused_acc_hi = ^acc[31:DEPTH_LOG2+2];

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Sequences LDR/STR uops from the issue stage into the dcache, one access at
//   a time. Request fields are registered on accept; the dcache sees exactly
//   one LDR/STR cycle (ISSUE); load data is captured at the end of CAPTURE;
//   the result is presented in RESP until writeback takes it.
//   Latency accept->out_valid: LDR 3, STR 2, pass-through/misaligned 1.
//
// Optional feature macro: LSU_WRITEBACK_EN
//   Defined: wb_valid/wb_base ports exist and report base writeback
//   (post-index, or pre-index with in_wb) for LDR/STR, misaligned included.
//   Undefined: those ports are absent and in_wb is ignored.
//
// Ports
//   clock, reset_n                 clock, async active-low reset
//   in_valid/in_ready              issue handshake (ready only in IDLE)
//   in_uop, in_base, in_offset,
//   in_up, in_pre, in_wb, in_rd,
//   in_store_data                  request fields
//   dc_addr, dc_data_in, dc_uop    dcache request (NOP_UOP when idle)
//   dc_data_out                    dcache registered read data
//   out_valid/out_ready            writeback handshake
//   out_rd, out_data, out_is_load,
//   out_misalign                   result fields (zero when out_valid=0)
//   wb_valid, wb_base              base writeback (LSU_WRITEBACK_EN only)
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int OFF_W      = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_uop,
  input  logic [31:0]       in_base,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic              in_up,
  input  logic              in_pre,
  input  logic              in_wb,
  input  logic [3:0]        in_rd,
  input  logic [31:0]       in_store_data,
  output logic [31:0]       dc_addr,
  output logic [31:0]       dc_data_in,
  output logic [4:0]        dc_uop,
  input  logic [31:0]       dc_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_rd,
  output logic [31:0]       out_data,
  output logic              out_is_load,
`ifdef LSU_WRITEBACK_EN
  output logic              wb_valid,
  output logic [31:0]       wb_base,
`endif
  output logic              out_misalign
);

  lsu_state_e state_q, state_d;

  logic [4:0]            req_uop_q;
  logic [DEPTH_LOG2-1:0] req_idx_q;
  logic [31:0]           req_data_q;
  logic [3:0]            req_rd_q;
  logic                  req_misalign_q;
  logic [31:0]           load_data_q;
  logic                  is_load_q;

  logic [31:0]           agu_eff;
  logic [DEPTH_LOG2-1:0] agu_idx;
  logic                  agu_misalign;
  logic                  accept;
  logic                  in_is_mem;

  lsu_agu #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .OFF_W     (OFF_W)
  ) u_agu (
    .base    (in_base),
    .offset  (in_offset),
    .up      (in_up),
    .pre     (in_pre),
    .eff     (agu_eff),
    .word_idx(agu_idx),
    .misalign(agu_misalign)
  );

  assign accept    = in_valid && (state_q == IDLE);
  assign in_is_mem = is_mem_uop(in_uop);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake/dcache/result outputs. Outputs are decoded
  // from registered state, so an async reset clears them immediately and an
  // aborted op can never produce a further dcache access.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    dc_uop       = NOP_UOP;
    dc_addr      = 32'd0;
    dc_data_in   = 32'd0;
    out_valid    = 1'b0;
    out_rd       = 4'd0;
    out_data     = 32'd0;
    out_is_load  = 1'b0;
    out_misalign = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          // Non-memory uops and misaligned accesses skip the dcache.
          if (in_is_mem && !agu_misalign) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        dc_uop  = req_uop_q;
        dc_addr = {{(32-DEPTH_LOG2){1'b0}}, req_idx_q};
        if (req_uop_q == STR_UOP) begin
          dc_data_in = req_data_q;
        end
        state_d = (req_uop_q == LDR_UOP) ? CAPTURE : RESP;
      end
      CAPTURE: begin
        state_d = RESP;
      end
      RESP: begin
        out_valid    = 1'b1;
        out_rd       = req_rd_q;
        out_data     = load_data_q;
        out_is_load  = is_load_q;
        out_misalign = req_misalign_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture on accept; load data captured at the end of CAPTURE,
  // the last cycle the dcache drives its read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_uop_q      <= NOP_UOP;
      req_idx_q      <= '0;
      req_data_q     <= 32'd0;
      req_rd_q       <= 4'd0;
      req_misalign_q <= 1'b0;
      load_data_q    <= 32'd0;
      is_load_q      <= 1'b0;
    end else begin
      if (accept) begin
        req_uop_q      <= in_uop;
        req_idx_q      <= agu_idx;
        req_data_q     <= in_store_data;
        req_rd_q       <= in_rd;
        req_misalign_q <= in_is_mem && agu_misalign;
        load_data_q    <= 32'd0;
        is_load_q      <= 1'b0;
      end else if (state_q == CAPTURE) begin
        load_data_q <= dc_data_out;
        is_load_q   <= 1'b1;
      end
    end
  end

`ifdef LSU_WRITEBACK_EN
  logic        req_wb_q;
  logic [31:0] req_eff_q;

  // Writeback applies to post-index always and to pre-index only on request;
  // misaligned LDR/STR still report it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_wb_q  <= 1'b0;
      req_eff_q <= 32'd0;
    end else if (accept) begin
      req_wb_q  <= in_is_mem && (!in_pre || in_wb);
      req_eff_q <= agu_eff;
    end
  end

  assign wb_valid = out_valid && req_wb_q;
  assign wb_base  = wb_valid ? req_eff_q : 32'd0;
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = ^{in_wb, agu_eff};
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] STR = 5'b01001;
  localparam logic [4:0] LDR = 5'b01010;
  localparam logic [4:0] OTHER = 5'b00101;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_uop = NOP;
  logic [31:0] in_base = 32'd0;
  logic [11:0] in_offset = 12'd0;
  logic        in_up = 1'b0;
  logic        in_pre = 1'b0;
  logic        in_wb = 1'b0;
  logic [3:0]  in_rd = 4'd0;
  logic [31:0] in_store_data = 32'd0;
  logic [31:0] dc_addr;
  logic [31:0] dc_data_in;
  logic [4:0]  dc_uop;
  logic [31:0] dc_data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_rd;
  logic [31:0] out_data;
  logic        out_is_load;
  logic        out_misalign;
`ifdef LSU_WRITEBACK_EN
  logic        wb_valid;
  logic [31:0] wb_base;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic        misalign;
    logic        wb_valid;
    logic [31:0] wb_base;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [0:31];
  logic        mem_init = 1'b1;
  logic [31:0] dc_mem [0:31];

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_uop       (in_uop),
    .in_base      (in_base),
    .in_offset    (in_offset),
    .in_up        (in_up),
    .in_pre       (in_pre),
    .in_wb        (in_wb),
    .in_rd        (in_rd),
    .in_store_data(in_store_data),
    .dc_addr      (dc_addr),
    .dc_data_in   (dc_data_in),
    .dc_uop       (dc_uop),
    .dc_data_out  (dc_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .out_is_load  (out_is_load),
`ifdef LSU_WRITEBACK_EN
    .wb_valid     (wb_valid),
    .wb_base      (wb_base),
`endif
    .out_misalign (out_misalign)
  );

  // dcache environment: registered read, garbage when not reading so a
  // capture in the wrong cycle shows up as bad data.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) dc_mem[i] <= 32'hA5A50000 + i;
      dc_data_out <= 32'hBAD0BAD0;
    end else begin
      if (dc_uop == STR) dc_mem[dc_addr[4:0]] <= dc_data_in;
      dc_data_out <= (dc_uop == LDR) ? dc_mem[dc_addr[4:0]] : 32'hBAD0BAD0;
    end
  end

  // Runs one op: pushes its expected result, drives it, measures latency and
  // dcache traffic, optionally stalls writeback, then pops and compares.
  task automatic do_op(input logic [4:0] uop, input logic [31:0] base,
                       input logic [11:0] off, input logic up, input logic pre,
                       input logic wb, input logic [3:0] rd,
                       input logic [31:0] sdata, input int hold,
                       input string name);
    logic [31:0] eff, acc;
    logic        is_mem, mis;
    logic [4:0]  idx;
    int          exp_lat, lat, dc_cnt, exp_cnt;
    logic [4:0]  got_uop;
    logic [31:0] got_addr, got_din;
    exp_t        e, g;
    eff    = up ? base + {20'd0, off} : base - {20'd0, off};
    acc    = pre ? eff : base;
    is_mem = (uop == LDR) || (uop == STR);
    mis    = is_mem && (acc[1:0] != 2'b00);
    idx    = acc[6:2];
    e.rd       = rd;
    e.misalign = mis;
    e.is_load  = (uop == LDR) && !mis;
    e.data     = e.is_load ? model_mem[idx] : 32'd0;
    e.wb_valid = is_mem && (!pre || wb);
    e.wb_base  = e.wb_valid ? eff : 32'd0;
    if (uop == STR && !mis) model_mem[idx] = sdata;
    exp_lat = (!is_mem || mis) ? 1 : ((uop == LDR) ? 3 : 2);
    exp_cnt = (is_mem && !mis) ? 1 : 0;
    sb.push_back(e);

    out_ready = (hold == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s in_ready_idle: got %b expected 1", name, in_ready);
    end
    in_valid = 1'b1; in_uop = uop; in_base = base; in_offset = off;
    in_up = up; in_pre = pre; in_wb = wb; in_rd = rd; in_store_data = sdata;
    @(negedge clock);
    in_valid = 1'b0; in_uop = LDR; in_base = $urandom; in_offset = 12'($urandom);
    in_up = ~up; in_pre = ~pre; in_rd = ~rd; in_store_data = $urandom;

    lat = 0; dc_cnt = 0; got_uop = NOP; got_addr = 32'd0; got_din = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      if (dc_uop !== NOP) begin
        dc_cnt++; got_uop = dc_uop; got_addr = dc_addr; got_din = dc_data_in;
      end
      if (out_valid === 1'b1) begin lat = k; break; end
      @(negedge clock);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("[TB] FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
    end
    checks++;
    if (dc_cnt != exp_cnt) begin
      errors++; $display("[TB] FAIL %s dc_access_count: got %0d expected %0d", name, dc_cnt, exp_cnt);
    end
    if (exp_cnt == 1) begin
      checks++;
      if (got_uop !== uop || got_addr !== {27'd0, idx}) begin
        errors++; $display("[TB] FAIL %s dc_req: got uop=%b addr=%0d expected uop=%b addr=%0d", name, got_uop, got_addr, uop, idx);
      end
      if (uop == STR) begin
        checks++;
        if (got_din !== sdata) begin
          errors++; $display("[TB] FAIL %s dc_data_in: got %h expected %h", name, got_din, sdata);
        end
      end
    end

    for (int h = 0; h < hold; h++) begin
      in_valid = h[0]; in_uop = LDR; in_base = {$urandom_range(0, 255), 2'b00};
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dc_uop !== NOP ||
          out_rd !== e.rd || out_data !== e.data || out_is_load !== e.is_load ||
          out_misalign !== e.misalign) begin
        errors++;
        $display("[TB] FAIL %s hold_stable: got v=%b rdy=%b dc=%b rd=%h d=%h ld=%b mis=%b expected v=1 rdy=0 dc=0 rd=%h d=%h ld=%b mis=%b",
                 name, out_valid, in_ready, dc_uop, out_rd, out_data, out_is_load, out_misalign,
                 e.rd, e.data, e.is_load, e.misalign);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    checks++;
    if (sb.size() == 0) begin
      errors++; $display("[TB] FAIL %s scoreboard_empty: got 0 entries expected 1", name);
    end else begin
      g = sb.pop_front();
      if (out_valid !== 1'b1 || out_rd !== g.rd || out_data !== g.data ||
          out_is_load !== g.is_load || out_misalign !== g.misalign) begin
        errors++;
        $display("[TB] FAIL %s result: got v=%b rd=%h data=%h ld=%b mis=%b expected v=1 rd=%h data=%h ld=%b mis=%b",
                 name, out_valid, out_rd, out_data, out_is_load, out_misalign, g.rd, g.data, g.is_load, g.misalign);
      end
`ifdef LSU_WRITEBACK_EN
      checks++;
      if (wb_valid !== g.wb_valid || wb_base !== g.wb_base) begin
        errors++; $display("[TB] FAIL %s writeback: got v=%b base=%h expected v=%b base=%h", name, wb_valid, wb_base, g.wb_valid, g.wb_base);
      end
`endif
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || dc_uop !== NOP || dc_addr !== 32'd0 || dc_data_in !== 32'd0 ||
        out_valid !== 1'b0 || out_rd !== 4'd0 || out_data !== 32'd0 ||
        out_is_load !== 1'b0 || out_misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rdy=%b dc=%b addr=%h din=%h v=%b rd=%h d=%h ld=%b mis=%b expected rdy=1 rest 0",
               in_ready, dc_uop, dc_addr, dc_data_in, out_valid, out_rd, out_data, out_is_load, out_misalign);
    end
`ifdef LSU_WRITEBACK_EN
    checks++;
    if (wb_valid !== 1'b0 || wb_base !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_wb: got v=%b base=%h expected 0", wb_valid, wb_base);
    end
`endif
    mem_init = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store_load;
    do_op(STR, 32'h10, 12'd4, 1'b1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 0, "str_pre");
    do_op(LDR, 32'h10, 12'd4, 1'b1, 1'b1, 1'b0, 4'd7, 32'h0, 0, "ldr_pre");
    do_op(LDR, 32'h94, 12'd0, 1'b1, 1'b1, 1'b0, 4'd8, 32'h0, 0, "ldr_alias");
  endtask

  task automatic test_post_index;
    do_op(LDR, 32'h20, 12'd8, 1'b0, 1'b0, 1'b0, 4'd2, 32'h0, 0, "ldr_post_down");
    do_op(STR, 32'h40, 12'd12, 1'b1, 1'b1, 1'b1, 4'd4, 32'h12345678, 0, "str_pre_wb");
  endtask

  task automatic test_misalign;
    do_op(LDR, 32'h13, 12'd0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 0, "ldr_misalign");
    do_op(STR, 32'h21, 12'd4, 1'b1, 1'b0, 1'b0, 4'd6, 32'hCAFEF00D, 0, "str_misalign_post");
    do_op(OTHER, 32'h44, 12'd4, 1'b1, 1'b1, 1'b1, 4'd9, 32'h0, 0, "passthrough");
  endtask

  task automatic test_wrap;
    do_op(STR, 32'h0, 12'd4, 1'b0, 1'b1, 1'b0, 4'd1, 32'h0BADCAFE, 0, "str_wrap");
    do_op(LDR, 32'h0, 12'd4, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0, 0, "ldr_wrap");
  endtask

  task automatic test_hold;
    do_op(LDR, 32'h14, 12'd0, 1'b1, 1'b1, 1'b0, 4'hA, 32'h0, 5, "ldr_hold");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0 || dc_uop !== NOP) begin
        errors++; $display("[TB] FAIL hold_ignored_pulse: got v=%b dc=%b expected v=0 dc=0", out_valid, dc_uop);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_midop_reset;
    in_valid = 1'b1; in_uop = LDR; in_base = 32'h14; in_offset = 12'd0;
    in_up = 1'b1; in_pre = 1'b1; in_wb = 1'b0; in_rd = 4'hB;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || dc_uop !== NOP || dc_addr !== 32'd0 || out_valid !== 1'b0 ||
        out_rd !== 4'd0 || out_data !== 32'd0 || out_is_load !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got rdy=%b dc=%b addr=%h v=%b rd=%h d=%h ld=%b expected rdy=1 rest 0",
               in_ready, dc_uop, dc_addr, out_valid, out_rd, out_data, out_is_load);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || dc_uop !== NOP || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL midop_discard: got v=%b dc=%b rdy=%b expected v=0 dc=0 rdy=1", out_valid, dc_uop, in_ready);
      end
    end
    do_op(LDR, 32'h14, 12'd0, 1'b1, 1'b1, 1'b0, 4'hC, 32'h0, 0, "ldr_after_reset");
  endtask

  task automatic test_back_to_back;
    logic [4:0]  uop;
    logic [31:0] base;
    logic [11:0] off;
    int          r;
    for (int n = 0; n < 12; n++) begin
      r    = $urandom_range(0, 9);
      uop  = (r < 4) ? LDR : ((r < 8) ? STR : OTHER);
      base = $urandom;
      if ($urandom_range(0, 3) != 0) base[1:0] = 2'b00;
      off  = 12'($urandom_range(0, 1023) * 4);
      do_op(uop, base, off, 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), $urandom, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hA5A50000 + i;
    test_reset();
    test_store_load();
    test_post_index();
    test_misalign();
    test_wrap();
    test_hold();
    test_midop_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
